// File: rtl/countdown_sequencer.sv
// Control FSM for the two-preset BCD countdown timer: sequences preset loads,
// per-second decrement strobes and the completion LED flash.
module countdown_sequencer #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int FLASH_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_pulse,
    input  logic        mode_pulse,
    input  logic        zero,
    output logic        load,
    output logic        preset_sel,
    output logic        dec_en,
    output logic        running,
    output logic [15:0] led,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

    state_t        cur_state;
    state_t        nxt_state;
    logic          toggle_sel;
    logic          tick;
    logic [TW-1:0] tick_cnt;
    logic [FW-1:0] flash_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= ST_PAUSE;
            preset_sel <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            preset_sel <= preset_sel ^ toggle_sel;
        end
    end

    // NOTE: every signal written here gets a default first, otherwise a path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        nxt_state  = cur_state;
        toggle_sel = 1'b0;
        unique case (cur_state)
            ST_LOAD: nxt_state = ST_PAUSE;
            ST_PAUSE: begin
                if (mode_pulse) begin
                    toggle_sel = 1'b1;
                    nxt_state  = ST_LOAD;
                end else if (en_pulse) begin
                    nxt_state = zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (mode_pulse) begin
                    toggle_sel = 1'b1;
                    nxt_state  = ST_LOAD;
                end else if (zero) begin
                    nxt_state = ST_DONE;
                end else if (en_pulse) begin
                    nxt_state = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (mode_pulse) begin
                    toggle_sel = 1'b1;
                    nxt_state  = ST_LOAD;
                end else if (en_pulse) begin
                    nxt_state = ST_LOAD;
                end
            end
        endcase
    end

    always_comb begin
        load    = (cur_state == ST_LOAD);
        running = (cur_state == ST_RUN);
        state   = cur_state;
        // Any pending pulse or zero pre-empts the tick, so no stray decrement.
        tick    = (cur_state == ST_RUN) && (tick_cnt == TICK_LAST) &&
                  !zero && !en_pulse && !mode_pulse;
    end

    // Tick phase restarts on each RUN entry; a paused partial second is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            dec_en   <= 1'b0;
        end else begin
            dec_en <= tick;
            if (cur_state == ST_RUN && nxt_state == ST_RUN)
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            else
                tick_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt <= '0;
            led       <= 16'h0000;
        end else if (nxt_state == ST_DONE && cur_state != ST_DONE) begin
            flash_cnt <= '0;
            led       <= 16'hFFFF;
        end else if (nxt_state == ST_DONE) begin
            if (flash_cnt == FLASH_LAST) begin
                flash_cnt <= '0;
                led       <= ~led;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
        end else begin
            flash_cnt <= '0;
            led       <= 16'h0000;
        end
    end

endmodule
